x_input_conditioner: RTL and testbench

//  Upstream stage for the sequence-detector top. Takes the raw slide/push input X from the

---
 rtl/x_input_conditioner_pkg.sv | 8 +
 rtl/x_input_conditioner_if.sv | 18 +
 rtl/step_tick_gen.sv | 23 ++
 rtl/x_input_conditioner.sv | 86 ++++++++
 tb/tb_x_input_conditioner.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/x_input_conditioner_pkg.sv
// fsm_pkg: shared debounce state encoding and default timing constants
//   CLK_HZ  board clock frequency
//   DB_MS   debounce window in milliseconds
package fsm_pkg;
  typedef enum logic [1:0] {LO_STABLE, LO_CHECK, HI_STABLE, HI_CHECK} db_state_t;
  localparam int CLK_HZ = 50_000_000;
  localparam int DB_MS = 20;
endpackage

// File: rtl/x_input_conditioner_if.sv
// x_input_conditioner_if: raw pin in, conditioned stream and step strobe out
//   x_raw    bouncing pin level
//   tick     one-cycle step strobe
//   x_level  debounced level
//   x_rise   one-cycle debounced rising-edge pulse
//   x_out    bit held for a whole step window
//   x_valid  one-cycle pulse after x_out updates
//   master = conditioner side, slave = pin driver / detector side
interface x_input_conditioner_if;
  logic x_raw;
  logic tick;
  logic x_level;
  logic x_rise;
  logic x_out;
  logic x_valid;
  modport master (input x_raw, output tick, x_level, x_rise, x_out, x_valid);
  modport slave (output x_raw, input tick, x_level, x_rise, x_out, x_valid);
endinterface

// File: rtl/step_tick_gen.sv
// step_tick_gen: one-cycle strobe every TICK_DIV cycles
//   clk, rst  clock and async active-high reset
//   tick      registered strobe, high while the phase counter sits at TICK_DIV-1
module step_tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  // tick is loaded one count early so it coincides with cnt == TICK_DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + 1'b1;
      tick <= cnt == CW'(TICK_DIV - 2);
    end
  end
endmodule

// File: rtl/x_input_conditioner.sv
// x_input_conditioner: synchronise, debounce and window-sample the X pin for the detector
//   clk, rst  fast clock and async active-high reset
//   bus       master side of x_input_conditioner_if (x_raw in; tick, x_level,
//             x_rise, x_out, x_valid out)
module x_input_conditioner
  import fsm_pkg::*;
#(
  parameter int TICK_DIV  = CLK_HZ,
  parameter int DB_CYCLES = CLK_HZ / 1000 * DB_MS
) (
  input logic clk,
  input logic rst,
  x_input_conditioner_if.master bus
);
  localparam int DW = $clog2(DB_CYCLES);
  logic s1, xs, press_seen, level_n, rise_n;
  logic [DW-1:0] cnt, cnt_n;
  db_state_t state, state_n;
  step_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(bus.tick));
  // The accepting compare uses DB_CYCLES-2 so the edge that accepts the change is the
  // one where the counter reaches DB_CYCLES-1, i.e. after DB_CYCLES matching samples.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    level_n = bus.x_level;
    rise_n = 1'b0;
    case (state)
      LO_STABLE: if (xs) begin
        state_n = LO_CHECK;
        cnt_n = '0;
      end
      LO_CHECK: if (!xs) state_n = LO_STABLE;
      else begin
        cnt_n = cnt + 1'b1;
        if (cnt == DW'(DB_CYCLES - 2)) begin
          state_n = HI_STABLE;
          level_n = 1'b1;
          rise_n = 1'b1;
        end
      end
      HI_STABLE: if (!xs) begin
        state_n = HI_CHECK;
        cnt_n = '0;
      end
      HI_CHECK: if (xs) state_n = HI_STABLE;
      else begin
        cnt_n = cnt + 1'b1;
        if (cnt == DW'(DB_CYCLES - 2)) begin
          state_n = LO_STABLE;
          level_n = 1'b0;
        end
      end
      default: state_n = LO_STABLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1, xs} <= '0;
      state <= LO_STABLE;
      cnt <= '0;
      bus.x_level <= 1'b0;
      bus.x_rise <= 1'b0;
    end else begin
      {s1, xs} <= {bus.x_raw, s1};
      state <= state_n;
      cnt <= cnt_n;
      bus.x_level <= level_n;
      bus.x_rise <= rise_n;
    end
  end
  // A rise coinciding with tick is folded into the current window and not remembered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_seen <= 1'b0;
      bus.x_out <= 1'b0;
      bus.x_valid <= 1'b0;
    end else if (bus.tick) begin
      press_seen <= 1'b0;
      bus.x_out <= bus.x_level | press_seen | bus.x_rise;
      bus.x_valid <= 1'b1;
    end else begin
      press_seen <= press_seen | bus.x_rise;
      bus.x_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_x_input_conditioner.sv
// tb_x_input_conditioner: directed and random stimulus against a run-length reference model
module tb_x_input_conditioner;
  import fsm_pkg::*;
  localparam int TD = 16;
  localparam int DB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic m_s1, m_xs, m_level, m_rise, m_tick, m_pend, m_out, m_valid;
  int m_run, m_phase;
  x_input_conditioner_if bus ();
  x_input_conditioner #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    {m_s1, m_xs, m_level, m_rise, m_tick, m_pend, m_out, m_valid} = '0;
    m_run = 0;
    m_phase = 0;
  endtask
  task automatic compare_all();
    chk("tick", bus.tick, m_tick);
    chk("x_level", bus.x_level, m_level);
    chk("x_rise", bus.x_rise, m_rise);
    chk("x_out", bus.x_out, m_out);
    chk("x_valid", bus.x_valid, m_valid);
  endtask
  // Model: level flips after DB consecutive synchronised samples that disagree with it;
  // the step phase is the edge count modulo TD; windows OR together every press.
  task automatic step();
    logic o_level, o_rise, o_tick, o_pend;
    @(posedge clk);
    {o_level, o_rise, o_tick, o_pend} = {m_level, m_rise, m_tick, m_pend};
    m_rise = 1'b0;
    if (m_xs != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_level = m_xs;
        m_rise = m_xs;
        m_run = 0;
      end
    end else m_run = 0;
    m_xs = m_s1;
    m_s1 = bus.x_raw;
    m_phase = (m_phase + 1) % TD;
    m_tick = m_phase == TD - 1;
    if (o_tick) begin
      m_out = o_level | o_pend | o_rise;
      m_valid = 1'b1;
      m_pend = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_pend = o_pend | o_rise;
    end
    @(negedge clk);
    compare_all();
  endtask
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * TD && !ok; i++) begin
      step();
      ok = bus.x_valid;
    end
  endtask
  task automatic wait_phase(input int p);
    for (int i = 0; i < TD && m_phase != p; i++) step();
  endtask
  initial begin
    bit ok, seen;
    bit [6:0] bounce;
    model_reset();
    bus.x_raw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.x_raw = ~bus.x_raw;
      #1 compare_all();
    end
    @(negedge clk);
    bus.x_raw = 1'b0;
    rst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      step();
      chk("tick_period", bus.tick, (n % TD) == TD - 1);
    end
    bus.x_raw = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("press_level", bus.x_level, i >= 6);
      chk("press_rise", bus.x_rise, i == 6);
    end
    wait_valid(ok);
    chk("press_valid_seen", ok, 1'b1);
    chk("press_out", bus.x_out, 1'b1);
    bus.x_raw = 1'b0;
    repeat (40) step();
    bounce = 7'b0110111;
    seen = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.x_raw = bounce[i];
      step();
      seen |= bus.x_level | bus.x_rise | bus.x_out;
    end
    bus.x_raw = 1'b0;
    repeat (2 * TD) begin
      step();
      seen |= bus.x_level | bus.x_rise | bus.x_out;
    end
    chk("bounce_quiet", seen, 1'b0);
    wait_phase(0);
    bus.x_raw = 1'b1;
    repeat (5) step();
    bus.x_raw = 1'b0;
    wait_valid(ok);
    chk("short_valid_seen", ok, 1'b1);
    chk("short_out_hi", bus.x_out, 1'b1);
    chk("short_level_low", bus.x_level, 1'b0);
    wait_valid(ok);
    chk("short_valid2_seen", ok, 1'b1);
    chk("short_out_lo", bus.x_out, 1'b0);
    wait_phase(9);
    bus.x_raw = 1'b1;
    repeat (6) step();
    chk("coin_rise", bus.x_rise, 1'b1);
    chk("coin_tick", bus.tick, 1'b1);
    bus.x_raw = 1'b0;
    step();
    chk("coin_out", bus.x_out, 1'b1);
    chk("coin_valid", bus.x_valid, 1'b1);
    chk("coin_press_cleared", dut.press_seen, 1'b0);
    wait_valid(ok);
    chk("coin_valid2_seen", ok, 1'b1);
    chk("coin_out_next", bus.x_out, 1'b0);
    repeat (40) begin
      bus.x_raw = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) step();
    end
    bus.x_raw = 1'b1;
    repeat (10) step();
    chk("pre_rst_level", bus.x_level, 1'b1);
    bus.x_raw = 1'b0;
    repeat (3) step();
    chk("in_hi_check", dut.state == HI_CHECK, 1'b1);
    #2 rst = 1'b1;
    #1 model_reset();
    compare_all();
    chk("rst_state", dut.state == LO_STABLE, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 2 * TD; n++) begin
      step();
      chk("tick_restart", bus.tick, (n % TD) == TD - 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
